// File: rtl/grant_lock_tracker_pkg.sv
// Shared types and helpers for grant_lock_tracker: FSM state encoding and a one-hot check.
package grant_lock_tracker_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Callers zero-extend narrower vectors; extra zero bits do not change the count.
    function automatic logic is_onehot(input logic [31:0] v);
        return $countones(v) == 1;
    endfunction

endpackage

// File: rtl/grant_lock_tracker_onehot_to_bin.sv
// Combinational one-hot to binary encoder for the arbiter grant vector.
module grant_lock_tracker_onehot_to_bin #(
    parameter int IO_SIZE = 5,
    parameter int IO_w    = 3
) (
    input  logic [IO_SIZE-1:0] onehot,
    output logic [IO_w-1:0]    idx
);

    // OR of the indices of all set bits; exact for a valid one-hot input.
    always_comb begin
        idx = '0;
        for (int i = 0; i < IO_SIZE; i++) begin
            if (onehot[i]) idx = idx | IO_w'(i);
        end
    end

endmodule

// File: rtl/grant_lock_tracker.sv
// Locks an arbiter grant from head to tail flit and gates transfers on downstream credits.
// Optional macro GRANT_LOCK_SINGLE_FLIT_BYPASS_EN: single-flit grants fire in the grant cycle.
module grant_lock_tracker
    import grant_lock_tracker_pkg::*;
#(
    parameter int IO_SIZE = 5,
    parameter int IO_w    = 3,
    parameter int CREDITS = 4,
    parameter int CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IO_SIZE-1:0] req_in,
    output logic [IO_SIZE-1:0] req_to_arb,
    input  logic [IO_SIZE-1:0] grant_onehot_in,
    input  logic [IO_SIZE-1:0] flit_valid_in,
    input  logic [IO_SIZE-1:0] flit_tail_in,
    input  logic               credit_return_in,
    output logic [IO_SIZE-1:0] grant_out,
    output logic [IO_w-1:0]    grant_idx_out,
    output logic               grant_valid_out,
    output logic               fire_out,
    output logic [CNT_W-1:0]   credit_cnt_out,
    output logic               err_out
);

    state_t             state, next_state;
    logic [IO_SIZE-1:0] grant_reg;
    logic [IO_w-1:0]    idx_reg;
    logic [IO_w-1:0]    enc_idx;
    logic [CNT_W-1:0]   credit_cnt;
    logic               err;
    logic               has_credit;
    logic               lock;
    logic               release_lock;
    logic               bypass;
    logic               grant_err;

    grant_lock_tracker_onehot_to_bin #(
        .IO_SIZE (IO_SIZE),
        .IO_w    (IO_w)
    ) u_enc (
        .onehot (grant_onehot_in),
        .idx    (enc_idx)
    );

    assign has_credit = (credit_cnt != '0);

    always_comb begin
        next_state   = state;
        req_to_arb   = '0;
        fire_out     = 1'b0;
        lock         = 1'b0;
        release_lock = 1'b0;
        bypass       = 1'b0;
        grant_err    = 1'b0;
        case (state)
            IDLE: begin
                req_to_arb = has_credit ? req_in : '0;
                if (|grant_onehot_in) begin
                    // A grant for a requester that was not forwarded is a protocol error.
                    if (!is_onehot(32'(grant_onehot_in)) || |(grant_onehot_in & ~req_to_arb)) begin
                        grant_err = 1'b1;
                    end else begin
`ifdef GRANT_LOCK_SINGLE_FLIT_BYPASS_EN
                        if (|(grant_onehot_in & flit_valid_in & flit_tail_in) && has_credit) begin
                            bypass   = 1'b1;
                            fire_out = 1'b1;
                        end else begin
                            lock       = 1'b1;
                            next_state = LOCKED;
                        end
`else
                        lock       = 1'b1;
                        next_state = LOCKED;
`endif
                    end
                end
            end
            LOCKED: begin
                fire_out = |(flit_valid_in & grant_reg) && has_credit;
                if (fire_out && |(flit_tail_in & grant_reg)) begin
                    release_lock = 1'b1;
                    next_state   = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_reg <= '0;
            idx_reg   <= '0;
        end else begin
            state <= next_state;
            if (lock) begin
                grant_reg <= grant_onehot_in;
                idx_reg   <= enc_idx;
            end else if (release_lock) begin
                grant_reg <= '0;
                idx_reg   <= '0;
            end
        end
    end

    // Simultaneous fire and return cancel; a return at full credit saturates and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= CNT_W'(CREDITS);
            err        <= 1'b0;
        end else begin
            if (grant_err) err <= 1'b1;
            if (credit_return_in && !fire_out) begin
                if (credit_cnt == CNT_W'(CREDITS)) err <= 1'b1;
                else credit_cnt <= credit_cnt + 1'b1;
            end else if (fire_out && !credit_return_in) begin
                credit_cnt <= credit_cnt - 1'b1;
            end
        end
    end

    assign grant_out       = grant_reg;
    assign grant_valid_out = (state == LOCKED);
    assign grant_idx_out   = bypass ? enc_idx : idx_reg;
    assign credit_cnt_out  = credit_cnt;
    assign err_out         = err;

endmodule

// File: tb/tb_grant_lock_tracker.sv
// Directed bench for grant_lock_tracker: vector table for the main packet flow plus corner sequences.
module tb_grant_lock_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] req_in, req_to_arb, grant_onehot_in, flit_valid_in, flit_tail_in, grant_out;
    logic [2:0] grant_idx_out, credit_cnt_out;
    logic       credit_return_in, grant_valid_out, fire_out, err_out;

    int total = 0;
    int bad   = 0;

    grant_lock_tracker dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_in           (req_in),
        .req_to_arb       (req_to_arb),
        .grant_onehot_in  (grant_onehot_in),
        .flit_valid_in    (flit_valid_in),
        .flit_tail_in     (flit_tail_in),
        .credit_return_in (credit_return_in),
        .grant_out        (grant_out),
        .grant_idx_out    (grant_idx_out),
        .grant_valid_out  (grant_valid_out),
        .fire_out         (fire_out),
        .credit_cnt_out   (credit_cnt_out),
        .err_out          (err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] req, gnt, fv, ft;
        logic       cr;
        logic [4:0] e_rta;
        logic       e_fire, e_gv;
        logic [2:0] e_idx, e_cnt;
        logic       e_err;
    } vec_t;

    vec_t tv[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] r, input logic [4:0] g, input logic [4:0] v,
                         input logic [4:0] t, input logic c);
        req_in = r; grant_onehot_in = g; flit_valid_in = v; flit_tail_in = t; credit_return_in = c;
    endtask

    task automatic idle_inputs();
        drive(5'b0, 5'b0, 5'b0, 5'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".grant"}, 32'(grant_out), 32'h0);
        chk({tag, ".idx"},   32'(grant_idx_out), 32'h0);
        chk({tag, ".gv"},    32'(grant_valid_out), 32'h0);
        chk({tag, ".fire"},  32'(fire_out), 32'h0);
        chk({tag, ".err"},   32'(err_out), 32'h0);
        chk({tag, ".cnt"},   32'(credit_cnt_out), 32'd4);
    endtask

    initial begin
        // req gnt fv ft cr | rta fire gv idx cnt err   (expected sampled before the edge)
        tv[0]  = '{5'b00100, 5'b00100, 5'b00000, 5'b00000, 1'b0, 5'b00100, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0};
        tv[1]  = '{5'b00100, 5'b00000, 5'b00100, 5'b00000, 1'b0, 5'b00000, 1'b1, 1'b1, 3'd2, 3'd4, 1'b0};
        tv[2]  = '{5'b00000, 5'b00000, 5'b01100, 5'b00000, 1'b0, 5'b00000, 1'b1, 1'b1, 3'd2, 3'd3, 1'b0};
        tv[3]  = '{5'b00000, 5'b00000, 5'b00100, 5'b00100, 1'b0, 5'b00000, 1'b1, 1'b1, 3'd2, 3'd2, 1'b0};
        tv[4]  = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0};
        tv[5]  = '{5'b10000, 5'b10000, 5'b00000, 5'b00000, 1'b0, 5'b10000, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0};
        tv[6]  = '{5'b10000, 5'b00000, 5'b10000, 5'b00000, 1'b0, 5'b00000, 1'b1, 1'b1, 3'd4, 3'd1, 1'b0};
        tv[7]  = '{5'b10000, 5'b00000, 5'b10000, 5'b10000, 1'b0, 5'b00000, 1'b0, 1'b1, 3'd4, 3'd0, 1'b0};
        tv[8]  = '{5'b10000, 5'b00000, 5'b10000, 5'b10000, 1'b1, 5'b00000, 1'b0, 1'b1, 3'd4, 3'd0, 1'b0};
        tv[9]  = '{5'b10000, 5'b00000, 5'b10000, 5'b10000, 1'b0, 5'b00000, 1'b1, 1'b1, 3'd4, 3'd1, 1'b0};
        tv[10] = '{5'b00010, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0};
        tv[11] = '{5'b00010, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0};
        tv[12] = '{5'b00010, 5'b00010, 5'b00000, 5'b00000, 1'b0, 5'b00010, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0};
        tv[13] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b1, 3'd1, 3'd1, 1'b0};
        tv[14] = '{5'b00000, 5'b00000, 5'b00010, 5'b00000, 1'b1, 5'b00000, 1'b1, 1'b1, 3'd1, 3'd2, 1'b0};
        tv[15] = '{5'b00000, 5'b00000, 5'b00010, 5'b00010, 1'b0, 5'b00000, 1'b1, 1'b1, 3'd1, 3'd2, 1'b0};
        tv[16] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0};
        tv[17] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0, 3'd0, 3'd2, 1'b0};
        tv[18] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0, 3'd0, 3'd3, 1'b0};
        tv[19] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0};
        tv[20] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 3'd4, 1'b1};

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        chk("reset.rta", 32'(req_to_arb), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drive(tv[i].req, tv[i].gnt, tv[i].fv, tv[i].ft, tv[i].cr);
            #1;
            chk($sformatf("v%0d.rta", i),  32'(req_to_arb),      32'(tv[i].e_rta));
            chk($sformatf("v%0d.fire", i), 32'(fire_out),        32'(tv[i].e_fire));
            chk($sformatf("v%0d.gv", i),   32'(grant_valid_out), 32'(tv[i].e_gv));
            chk($sformatf("v%0d.idx", i),  32'(grant_idx_out),   32'(tv[i].e_idx));
            chk($sformatf("v%0d.cnt", i),  32'(credit_cnt_out),  32'(tv[i].e_cnt));
            chk($sformatf("v%0d.err", i),  32'(err_out),         32'(tv[i].e_err));
            @(negedge clk);
        end

        // Multi-bit grant: no lock, sticky error until reset.
        do_reset();
        drive(5'b00110, 5'b00110, 5'b0, 5'b0, 1'b0);
        #1 chk("multi.rta", 32'(req_to_arb), 32'b00110);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("multi.gv", 32'(grant_valid_out), 32'h0);
        chk("multi.err", 32'(err_out), 32'h1);
        repeat (3) @(negedge clk);
        chk("multi.sticky", 32'(err_out), 32'h1);
        do_reset();
        #1 chk("multi.cleared", 32'(err_out), 32'h0);

        // Grant for a requester that did not request.
        drive(5'b00001, 5'b00100, 5'b0, 5'b0, 1'b0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("unreq.gv", 32'(grant_valid_out), 32'h0);
        chk("unreq.err", 32'(err_out), 32'h1);

        // Reset mid-packet with one credit left.
        do_reset();
        drive(5'b00100, 5'b00100, 5'b0, 5'b0, 1'b0);
        @(negedge clk);
        drive(5'b00100, 5'b00000, 5'b00100, 5'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("midrst.pre_cnt", 32'(credit_cnt_out), 32'd1);
        chk("midrst.pre_gv", 32'(grant_valid_out), 32'h1);
        idle_inputs();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;

        // Single-flit packet: bypass fires in the grant cycle, otherwise it locks first.
        @(negedge clk);
        drive(5'b01000, 5'b01000, 5'b01000, 5'b01000, 1'b0);
        #1;
`ifdef GRANT_LOCK_SINGLE_FLIT_BYPASS_EN
        chk("single.fire0", 32'(fire_out), 32'h1);
        chk("single.idx0", 32'(grant_idx_out), 32'd3);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("single.gv1", 32'(grant_valid_out), 32'h0);
        chk("single.cnt1", 32'(credit_cnt_out), 32'd3);
`else
        chk("single.fire0", 32'(fire_out), 32'h0);
        @(negedge clk);
        drive(5'b00000, 5'b00000, 5'b01000, 5'b01000, 1'b0);
        #1;
        chk("single.gv1", 32'(grant_valid_out), 32'h1);
        chk("single.idx1", 32'(grant_idx_out), 32'd3);
        chk("single.fire1", 32'(fire_out), 32'h1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("single.gv2", 32'(grant_valid_out), 32'h0);
        chk("single.cnt2", 32'(credit_cnt_out), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
